// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter
// Shares one framebuffer write port between four drawing engines
// (start screen, clear, maze/special, box draw/erase). One engine owns the
// port for a whole burst. A watchdog frees the port from an owner that has
// stopped plotting. Plots from engines that do not own the port are
// counted and discarded.

module vga_write_arbiter #(
   parameter int X_W     = 8,
   parameter int Y_W     = 7,
   parameter int C_W     = 3,
   parameter int TIMEOUT = 1023
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic [3:0]         req,
   input  logic [3:0]         release_in,
   input  logic [3:0]         plot,
   input  logic [4*X_W-1:0]   x_in,
   input  logic [4*Y_W-1:0]   y_in,
   input  logic [4*C_W-1:0]   colour_in,
   output logic [3:0]         grant,
   output logic               busy,
   output logic [X_W-1:0]     vga_x,
   output logic [Y_W-1:0]     vga_y,
   output logic [C_W-1:0]     vga_colour,
   output logic               vga_writeEn,
   output logic [7:0]         drop_count,
   output logic               timeout_err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] OWN  = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;

   // The watchdog holds the number of idle cycles already seen, so the
   // current idle cycle is the TIMEOUT-th one when it equals TIMEOUT-1.
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

   logic [1:0]     state;
   logic [1:0]     lastOwner;
   logic [1:0]     winner;
   logic [1:0]     candidate;
   logic           winnerFound;
   logic           acceptPlot;
   logic           watchdogExpire;
   logic           releaseNow;
   logic [15:0]    watchdog;
   logic [X_W-1:0] selX;
   logic [Y_W-1:0] selY;
   logic [C_W-1:0] selC;
   logic [3:0]     rejected;
   logic [2:0]     rejectCount;
   logic [8:0]     dropSum;

   // Round-robin search: scan the engines starting just after the last
   // owner, wrapping round so the last owner itself is considered last.
   always_comb begin
      winnerFound = 1'b0;
      winner      = lastOwner;
      candidate   = lastOwner;
      for (int k = 1; k <= 4; k++) begin
         candidate = lastOwner + 2'(k);
         if (!winnerFound && req[candidate]) begin
            winnerFound = 1'b1;
            winner      = candidate;
         end
      end
   end

   // Owner bookkeeping: a plot is accepted only from the granted engine,
   // and the burst ends on release, dropped request or watchdog expiry.
   always_comb begin
      acceptPlot     = |(grant & plot);
      watchdogExpire = (state == OWN) && !acceptPlot && (watchdog >= WD_LAST);
      releaseNow     = (state == OWN) &&
                       (release_in[lastOwner] || !req[lastOwner] || watchdogExpire);
   end

   // Select the current owner's pixel fields from the packed input buses.
   always_comb begin
      selX = '0;
      selY = '0;
      selC = '0;
      for (int i = 0; i < 4; i++) begin
         if (lastOwner == 2'(i)) begin
            selX = x_in[i*X_W +: X_W];
            selY = y_in[i*Y_W +: Y_W];
            selC = colour_in[i*C_W +: C_W];
         end
      end
   end

   // Count plots from engines without a grant and form the saturating sum.
   always_comb begin
      rejected    = plot & ~grant;
      rejectCount = 3'd0;
      for (int i = 0; i < 4; i++) begin
         rejectCount = rejectCount + 3'(rejected[i]);
      end
      dropSum = {1'b0, drop_count} + {6'd0, rejectCount};
   end

   // Arbitration FSM. lastOwner doubles as the current owner while in OWN,
   // and GAP forces at least one grant-free cycle between bursts.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         grant     <= 4'b0000;
         lastOwner <= 2'd3;
      end else begin
         case (state)
            IDLE: begin
               if (winnerFound) begin
                  state     <= OWN;
                  grant     <= 4'b0001 << winner;
                  lastOwner <= winner;
               end
            end
            OWN: begin
               if (releaseNow) begin
                  state <= GAP;
                  grant <= 4'b0000;
               end
            end
            GAP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               grant <= 4'b0000;
            end
         endcase
      end
   end

   // Watchdog counts consecutive OWN cycles without an accepted plot; it
   // rests at zero outside OWN so every new burst starts from a clean count.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         watchdog <= 16'd0;
      end else if ((state == OWN) && !acceptPlot) begin
         watchdog <= watchdog + 16'd1;
      end else begin
         watchdog <= 16'd0;
      end
   end

   // Registered pixel output: one cycle latency, coordinates held between
   // writes so the framebuffer port sees stable values.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         vga_writeEn <= 1'b0;
         vga_x       <= '0;
         vga_y       <= '0;
         vga_colour  <= '0;
      end else begin
         vga_writeEn <= acceptPlot;
         if (acceptPlot) begin
            vga_x      <= selX;
            vga_y      <= selY;
            vga_colour <= selC;
         end
      end
   end

   // Saturating tally of rejected plots, useful for spotting engines that
   // draw without first winning the port.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         drop_count <= 8'd0;
      end else if (dropSum[8]) begin
         drop_count <= 8'hFF;
      end else begin
         drop_count <= dropSum[7:0];
      end
   end

   // Sticky watchdog flag; only a reset clears it.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         timeout_err <= 1'b0;
      end else if (watchdogExpire) begin
         timeout_err <= 1'b1;
      end
   end

   assign busy = |grant;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Testbench for vga_write_arbiter: directed scenarios plus a randomized run
// compared against a burst-level reference model.

module tb_vga_write_arbiter;

   localparam int X_W     = 8;
   localparam int Y_W     = 7;
   localparam int C_W     = 3;
   localparam int TIMEOUT = 4;

   logic             clock = 1'b0;
   logic             resetn = 1'b0;
   logic [3:0]       req = '0;
   logic [3:0]       releaseIn = '0;
   logic [3:0]       plot = '0;
   logic [4*X_W-1:0] xIn = '0;
   logic [4*Y_W-1:0] yIn = '0;
   logic [4*C_W-1:0] cIn = '0;
   logic [3:0]       grant;
   logic             busy;
   logic [X_W-1:0]   vgaX;
   logic [Y_W-1:0]   vgaY;
   logic [C_W-1:0]   vgaColour;
   logic             vgaWriteEn;
   logic [7:0]       dropCount;
   logic             timeoutErr;

   int checkCount = 0;
   int errorCount = 0;

   // Reference model: which engine owns the port (-1 none), whether a gap
   // cycle is still owed, idle cycles in the current burst, and outputs.
   int             mOwner;
   int             mLast;
   int             mIdle;
   bit             mGap;
   logic [3:0]     expGrant;
   logic           expWe;
   logic [X_W-1:0] expX;
   logic [Y_W-1:0] expY;
   logic [C_W-1:0] expC;
   int             expDrop;
   logic           expErr;

   vga_write_arbiter #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .resetn(resetn), .req(req), .release_in(releaseIn), .plot(plot),
      .x_in(xIn), .y_in(yIn), .colour_in(cIn), .grant(grant), .busy(busy),
      .vga_x(vgaX), .vga_y(vgaY), .vga_colour(vgaColour), .vga_writeEn(vgaWriteEn),
      .drop_count(dropCount), .timeout_err(timeoutErr)
   );

   always #5 clock = ~clock;

   task automatic modelReset();
      mOwner = -1; mLast = 3; mIdle = 0; mGap = 0;
      expGrant = '0; expWe = 0; expX = '0; expY = '0; expC = '0;
      expDrop = 0; expErr = 0;
   endtask

   // Advance the model by one clock edge using the currently driven inputs.
   task automatic modelStep();
      int drops;
      bit acc;
      bit tmo;
      drops = 0;
      expWe = 0;
      for (int i = 0; i < 4; i++) if (plot[i] && i != mOwner) drops++;
      if (mOwner >= 0) begin
         acc = plot[mOwner];
         if (acc) begin
            expWe = 1;
            expX = xIn[mOwner*X_W +: X_W];
            expY = yIn[mOwner*Y_W +: Y_W];
            expC = cIn[mOwner*C_W +: C_W];
            mIdle = 0;
         end else begin
            mIdle++;
         end
         tmo = !acc && (mIdle >= TIMEOUT);
         if (tmo) expErr = 1;
         if (releaseIn[mOwner] || !req[mOwner] || tmo) begin
            mOwner = -1;
            mGap = 1;
         end
      end else if (mGap) begin
         mGap = 0;
      end else if (req != 4'b0) begin
         for (int k = 1; k <= 4; k++) begin
            int c;
            c = (mLast + k) % 4;
            if (mOwner < 0 && req[c]) mOwner = c;
         end
         mLast = mOwner;
         mIdle = 0;
      end
      expDrop = (expDrop + drops > 255) ? 255 : expDrop + drops;
      expGrant = (mOwner >= 0) ? 4'(1 << mOwner) : 4'b0000;
   endtask

   // Drive one cycle of control inputs, step the model, sample after the edge.
   task automatic applyStimulus(input logic [3:0] r, input logic [3:0] rl, input logic [3:0] p);
      req = r;
      releaseIn = rl;
      plot = p;
      modelStep();
      @(posedge clock);
      #1;
   endtask

   task automatic doReset();
      req = '0; releaseIn = '0; plot = '0;
      resetn = 1'b0;
      modelReset();
      @(posedge clock);
      #1;
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      req = 4'hF; plot = 4'hF; releaseIn = '0;
      xIn = $urandom; yIn = 28'($urandom); cIn = 12'($urandom);
      resetn = 1'b0;
      modelReset();
      @(posedge clock);
      #1;
      checkCount++;
      if (grant !== 4'b0 || busy !== 1'b0) begin
         errorCount++; $display("[TB] FAIL reset_grant: got grant=%b busy=%b expected 0000/0", grant, busy);
      end
      checkCount++;
      if (vgaWriteEn !== 1'b0) begin
         errorCount++; $display("[TB] FAIL reset_we: got %b expected 0", vgaWriteEn);
      end
      checkCount++;
      if ({vgaX, vgaY, vgaColour} !== '0) begin
         errorCount++; $display("[TB] FAIL reset_pixel: got %h/%h/%h expected 0/0/0", vgaX, vgaY, vgaColour);
      end
      checkCount++;
      if (dropCount !== 8'd0 || timeoutErr !== 1'b0) begin
         errorCount++; $display("[TB] FAIL reset_status: got drop=%0d err=%b expected 0/0", dropCount, timeoutErr);
      end
      req = '0; plot = '0;
      resetn = 1'b1;
   endtask

   task automatic test_single_engine();
      doReset();
      xIn = '0; yIn = '0; cIn = '0;
      xIn[7:0] = 8'd5; yIn[6:0] = 7'd3; cIn[2:0] = 3'd7;
      applyStimulus(4'b0001, 4'b0000, 4'b0000);
      checkCount++;
      if (grant !== 4'b0001 || busy !== 1'b1) begin
         errorCount++; $display("[TB] FAIL single_grant: got grant=%b busy=%b expected 0001/1", grant, busy);
      end
      for (int n = 0; n < 2; n++) begin
         applyStimulus(4'b0001, 4'b0000, 4'b0001);
         checkCount++;
         if (vgaWriteEn !== 1'b1 || {vgaX, vgaY, vgaColour} !== {8'd5, 7'd3, 3'd7}) begin
            errorCount++; $display("[TB] FAIL single_pixel: got we=%b (%0d,%0d,%0d) expected 1 (5,3,7)",
                                   vgaWriteEn, vgaX, vgaY, vgaColour);
         end
         applyStimulus(4'b0001, 4'b0000, 4'b0000);
         checkCount++;
         if (vgaWriteEn !== 1'b0) begin
            errorCount++; $display("[TB] FAIL single_no_plot: got we=%b expected 0", vgaWriteEn);
         end
      end
      applyStimulus(4'b0001, 4'b0001, 4'b0000);
      checkCount++;
      if (grant !== 4'b0000 || busy !== 1'b0) begin
         errorCount++; $display("[TB] FAIL single_gap: got grant=%b busy=%b expected 0000/0", grant, busy);
      end
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
   endtask

   task automatic test_round_robin();
      logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      int ownerIdx [5] = '{0, 1, 2, 3, 0};
      int waited;
      doReset();
      for (int n = 0; n < 5; n++) begin
         waited = 1;
         applyStimulus(4'hF, 4'b0000, 4'b0000);
         while (grant === 4'b0000 && waited < 8) begin
            applyStimulus(4'hF, 4'b0000, 4'b0000);
            waited++;
         end
         checkCount++;
         if (grant !== order[n]) begin
            errorCount++; $display("[TB] FAIL rr_order[%0d]: got %b expected %b", n, grant, order[n]);
         end
         for (int p = 0; p < 2; p++) begin
            xIn = $urandom;
            applyStimulus(4'hF, 4'b0000, 4'(1 << ownerIdx[n]));
            checkCount++;
            if (vgaWriteEn !== 1'b1 || vgaX !== xIn[ownerIdx[n]*X_W +: X_W]) begin
               errorCount++; $display("[TB] FAIL rr_pixel[%0d]: got we=%b x=%0d expected 1 x=%0d",
                                      n, vgaWriteEn, vgaX, xIn[ownerIdx[n]*X_W +: X_W]);
            end
         end
         applyStimulus(4'hF, 4'(1 << ownerIdx[n]), 4'b0000);
         checkCount++;
         if (grant !== 4'b0000) begin
            errorCount++; $display("[TB] FAIL rr_gap[%0d]: got %b expected 0000", n, grant);
         end
      end
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
   endtask

   task automatic test_drop_count();
      doReset();
      xIn = '0;
      xIn[1*X_W +: X_W] = 8'd17;
      xIn[2*X_W +: X_W] = 8'd34;
      xIn[3*X_W +: X_W] = 8'd200;
      applyStimulus(4'b1000, 4'b0000, 4'b0000);
      checkCount++;
      if (grant !== 4'b1000) begin
         errorCount++; $display("[TB] FAIL drop_grant: got %b expected 1000", grant);
      end
      applyStimulus(4'b1000, 4'b0000, 4'b0110);
      checkCount++;
      if (vgaWriteEn !== 1'b0) begin
         errorCount++; $display("[TB] FAIL drop_no_write_a: got we=%b expected 0", vgaWriteEn);
      end
      applyStimulus(4'b1000, 4'b0000, 4'b1110);
      checkCount++;
      if (vgaWriteEn !== 1'b1 || vgaX !== 8'd200) begin
         errorCount++; $display("[TB] FAIL drop_owner_write: got we=%b x=%0d expected 1 x=200", vgaWriteEn, vgaX);
      end
      applyStimulus(4'b1000, 4'b0000, 4'b0110);
      checkCount++;
      if (vgaWriteEn !== 1'b0) begin
         errorCount++; $display("[TB] FAIL drop_no_write_c: got we=%b expected 0", vgaWriteEn);
      end
      checkCount++;
      if (dropCount !== 8'd6) begin
         errorCount++; $display("[TB] FAIL drop_count: got %0d expected 6", dropCount);
      end
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
   endtask

   task automatic test_timeout();
      doReset();
      applyStimulus(4'b0100, 4'b0000, 4'b0000);
      for (int i = 1; i <= 3; i++) applyStimulus(4'b0100, 4'b0000, 4'b0000);
      checkCount++;
      if (grant !== 4'b0100 || timeoutErr !== 1'b0) begin
         errorCount++; $display("[TB] FAIL timeout_hold: got grant=%b err=%b expected 0100/0", grant, timeoutErr);
      end
      applyStimulus(4'b0100, 4'b0000, 4'b0000);
      checkCount++;
      if (grant !== 4'b0000 || timeoutErr !== 1'b1) begin
         errorCount++; $display("[TB] FAIL timeout_fire: got grant=%b err=%b expected 0000/1", grant, timeoutErr);
      end
      applyStimulus(4'b0100, 4'b0000, 4'b0000);
      applyStimulus(4'b0100, 4'b0000, 4'b0000);
      checkCount++;
      if (grant !== 4'b0100 || timeoutErr !== 1'b1) begin
         errorCount++; $display("[TB] FAIL timeout_sticky: got grant=%b err=%b expected 0100/1", grant, timeoutErr);
      end
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
   endtask

   task automatic test_plot_release_same_cycle();
      logic [X_W-1:0] ex;
      logic [Y_W-1:0] ey;
      logic [C_W-1:0] ec;
      doReset();
      xIn = $urandom; yIn = 28'($urandom); cIn = 12'($urandom);
      ex = xIn[1*X_W +: X_W]; ey = yIn[1*Y_W +: Y_W]; ec = cIn[1*C_W +: C_W];
      applyStimulus(4'b0010, 4'b0000, 4'b0000);
      checkCount++;
      if (grant !== 4'b0010) begin
         errorCount++; $display("[TB] FAIL same_grant: got %b expected 0010", grant);
      end
      applyStimulus(4'b0010, 4'b0010, 4'b0010);
      checkCount++;
      if (vgaWriteEn !== 1'b1 || {vgaX, vgaY, vgaColour} !== {ex, ey, ec} || grant !== 4'b0000) begin
         errorCount++; $display("[TB] FAIL same_cycle: got we=%b (%0d,%0d,%0d) grant=%b expected 1 (%0d,%0d,%0d) 0000",
                                vgaWriteEn, vgaX, vgaY, vgaColour, grant, ex, ey, ec);
      end
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
   endtask

   task automatic test_reset_mid_burst();
      doReset();
      xIn = $urandom | 32'h0101_0101; yIn = 28'($urandom); cIn = 12'($urandom);
      applyStimulus(4'b0100, 4'b0000, 4'b0000);
      applyStimulus(4'b0100, 4'b0000, 4'b0100);
      checkCount++;
      if (grant !== 4'b0100 || vgaWriteEn !== 1'b1) begin
         errorCount++; $display("[TB] FAIL midreset_pre: got grant=%b we=%b expected 0100/1", grant, vgaWriteEn);
      end
      req = 4'b0100; plot = 4'b0100;
      resetn = 1'b0;
      modelReset();
      #1;
      checkCount++;
      if (grant !== 4'b0 || busy !== 1'b0 || vgaWriteEn !== 1'b0) begin
         errorCount++; $display("[TB] FAIL midreset_ctrl: got grant=%b busy=%b we=%b expected 0", grant, busy, vgaWriteEn);
      end
      checkCount++;
      if ({vgaX, vgaY, vgaColour} !== '0 || dropCount !== 8'd0 || timeoutErr !== 1'b0) begin
         errorCount++; $display("[TB] FAIL midreset_data: got %h/%h/%h drop=%0d err=%b expected all 0",
                                vgaX, vgaY, vgaColour, dropCount, timeoutErr);
      end
      #1;
      resetn = 1'b1;
      applyStimulus(4'b0100, 4'b0000, 4'b0100);
      checkCount++;
      if (grant !== 4'b0100 || vgaWriteEn !== 1'b0) begin
         errorCount++; $display("[TB] FAIL midreset_rearb: got grant=%b we=%b expected 0100/0", grant, vgaWriteEn);
      end
      applyStimulus(4'b0100, 4'b0000, 4'b0100);
      checkCount++;
      if (vgaWriteEn !== 1'b1 || vgaX !== xIn[2*X_W +: X_W]) begin
         errorCount++; $display("[TB] FAIL midreset_write: got we=%b x=%0d expected 1 x=%0d",
                                vgaWriteEn, vgaX, xIn[2*X_W +: X_W]);
      end
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
   endtask

   task automatic test_random();
      logic [3:0] r;
      logic [3:0] rl;
      doReset();
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < 4; i++) begin
            r[i]  = ($urandom_range(99) < 75);
            rl[i] = ($urandom_range(99) < 8);
         end
         xIn = $urandom; yIn = 28'($urandom); cIn = 12'($urandom);
         applyStimulus(r, rl, 4'($urandom));
         checkCount++;
         if (grant !== expGrant || busy !== (|expGrant)) begin
            errorCount++; $display("[TB] FAIL rand_grant[%0d]: got %b/%b expected %b/%b", n, grant, busy, expGrant, |expGrant);
         end
         checkCount++;
         if (vgaWriteEn !== expWe || {vgaX, vgaY, vgaColour} !== {expX, expY, expC}) begin
            errorCount++; $display("[TB] FAIL rand_pixel[%0d]: got %b (%h,%h,%h) expected %b (%h,%h,%h)",
                                   n, vgaWriteEn, vgaX, vgaY, vgaColour, expWe, expX, expY, expC);
         end
         checkCount++;
         if (dropCount !== 8'(expDrop) || timeoutErr !== expErr) begin
            errorCount++; $display("[TB] FAIL rand_status[%0d]: got drop=%0d err=%b expected %0d/%b",
                                   n, dropCount, timeoutErr, expDrop, expErr);
         end
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_single_engine();
      test_round_robin();
      test_drop_count();
      test_timeout();
      test_plot_release_same_cycle();
      test_reset_mid_burst();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
